// File: rtl/merge2_arbiter.sv
// ---------------------------------------------------------------------------
// merge2_arbiter
//
// Upward hop of the tree NoC. Merges packets from two child links (In0, In1)
// onto a single parent link (Out). The two links are served round-robin, one
// packet at a time. Before each forwarded packet, the index of the granted link
// is sent as a 1-bit token on the S side channel. This is the same S-then-data
// order that the downward router expects.
//
// Each packet takes three handshakes: accept from a child, S token, Out packet.
// No packet is buffered beyond the one in flight. The packet is forwarded
// bit-exact; the address field is never inspected.
//
// Optional feature macro: ARB_STATS_EN
//   When defined, saturating per-link grant counters are built. They are
//   exposed on stat_cnt0 and stat_cnt1. When undefined, the counters and both
//   ports are absent, and the datapath behaves identically.
//
// Parameters
//   W       packet width ([8:5] destination address, [4:0] payload at W=9)
//   CNT_W   width of each grant counter (ARB_STATS_EN builds only)
//
// Ports
//   CLK, RESET            rising-edge clock, synchronous active-high reset
//   in0_data/valid/ready  child link 0 (ready is combinational, ARB state only)
//   in1_data/valid/ready  child link 1
//   s_data/valid/ready    side channel carrying the granted link index
//   out_data/valid/ready  parent link carrying the forwarded packet
//   stat_cnt0/stat_cnt1   grants per link (ARB_STATS_EN only)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module merge2_arbiter #(
   parameter int W     = 9,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [W-1:0]     in0_data,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [W-1:0]     in1_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   output logic             s_data,
   output logic             s_valid,
   input  logic             s_ready,
   output logic [W-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready
`ifdef ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_cnt0,
   output logic [CNT_W-1:0] stat_cnt1
`endif
);

   typedef enum logic [1:0] {
      ARB      = 2'd0,
      SEND_S   = 2'd1,
      SEND_OUT = 2'd2
   } state_t;

   state_t         state_reg, state_next;
   logic           last_grant_reg, last_grant_next;
   logic           grant_reg, grant_next;
   logic [W-1:0]   pkt_reg, pkt_next;

   logic           arb_any;     // at least one child is offering a packet
   logic           arb_grant;   // link that would win arbitration this cycle
   logic           accept;      // a child packet is taken this cycle

   // Round-robin: a lone requester always wins. On a tie, the link that
   // was not served last wins. last_grant only moves when a packet has
   // fully left on Out, so a reset-dropped packet does not count as served.
   always_comb begin
      arb_any = in0_valid | in1_valid;
      if (in0_valid && in1_valid) begin
         arb_grant = ~last_grant_reg;
      end else begin
         arb_grant = in1_valid;
      end
   end

   // Handshake outputs are masked while RESET is high. This keeps a child,
   // the S consumer or the parent from completing a transfer during the
   // cycle in which the in-flight packet is being discarded.
   assign accept = (state_reg == ARB) && arb_any && !RESET;

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      grant_next      = grant_reg;
      pkt_next        = pkt_reg;
      in0_ready       = 1'b0;
      in1_ready       = 1'b0;
      s_valid         = 1'b0;
      out_valid       = 1'b0;

      case (state_reg)
         ARB: begin
            if (accept) begin
               in0_ready  = ~arb_grant;
               in1_ready  = arb_grant;
               grant_next = arb_grant;
               pkt_next   = arb_grant ? in1_data : in0_data;
               state_next = SEND_S;
            end
         end
         SEND_S: begin
            s_valid = !RESET;
            if (s_ready) begin
               state_next = SEND_OUT;
            end
         end
         SEND_OUT: begin
            out_valid = !RESET;
            if (out_ready) begin
               last_grant_next = grant_reg;
               state_next      = ARB;
            end
         end
         default: begin
            state_next = ARB;
         end
      endcase
   end

   // Data outputs come straight from registers. They therefore stay stable
   // for as long as the downstream side applies backpressure.
   assign s_data   = grant_reg;
   assign out_data = pkt_reg;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg      <= ARB;
         last_grant_reg <= 1'b1;   // link 0 wins the first tie
         grant_reg      <= 1'b0;
         pkt_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         grant_reg      <= grant_next;
         pkt_reg        <= pkt_next;
      end
   end

`ifdef ARB_STATS_EN
   // One saturating counter per link. Each counter advances on the cycle
   // its link is accepted, i.e. on the ARB->SEND_S transition.
   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_stat
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge CLK) begin
         if (RESET) begin
            cnt_reg <= '0;
         end else if (accept && (arb_grant == (gi == 1)) && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign stat_cnt0 = g_stat[0].cnt_reg;
   assign stat_cnt1 = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_merge2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_merge2_arbiter
//
// Self-checking bench for merge2_arbiter. The bench runs four parts in order:
//   - a reset check;
//   - a table of per-cycle vectors covering first-packet latency,
//     alternation under continuous contention, and a single-link stream;
//   - hand-written sequences for backpressure, mid-packet reset and the
//     saturating grant counters (ARB_STATS_EN);
//   - randomized traffic checked against a transaction-level model. The model
//     holds queues of expected S tokens and Out packets, plus the round-robin
//     rule applied whenever nothing is in flight.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_merge2_arbiter;
   localparam int W     = 9;
   localparam int CNT_W = 2;
   localparam int NV    = 30;

   logic             CLK = 1'b0;
   logic             RESET = 1'b1;
   logic [W-1:0]     in0_data = '0;
   logic             in0_valid = 1'b0;
   logic             in0_ready;
   logic [W-1:0]     in1_data = '0;
   logic             in1_valid = 1'b0;
   logic             in1_ready;
   logic             s_data;
   logic             s_valid;
   logic             s_ready = 1'b0;
   logic [W-1:0]     out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
`ifdef ARB_STATS_EN
   logic [CNT_W-1:0] stat_cnt0;
   logic [CNT_W-1:0] stat_cnt1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   merge2_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .in0_data  (in0_data),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in1_data  (in1_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef ARB_STATS_EN
      ,
      .stat_cnt0 (stat_cnt0),
      .stat_cnt1 (stat_cnt1)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running, required finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Inputs are driven 1 ns after the rising edge. Outputs are sampled at 2 ns.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Returns at +2 ns with ok=1 once the link's ready is seen.
   task automatic wait_rdy(input int link, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if ((link == 0) ? in0_ready : in1_ready) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   typedef struct {
      logic         v0;
      logic         v1;
      logic [W-1:0] d0;
      logic [W-1:0] d1;
      logic         e_r0;
      logic         e_r1;
      logic         e_sv;
      logic         e_sd;
      logic         e_ov;
      logic [W-1:0] e_od;
   } vec_t;

   vec_t tbl [NV];

   initial begin
      int   pkt;
      int   ph;
      logic lk;
      logic seen0;
      logic seen1;
      int   n_out;
      int   seen_bad;
      bit   acc0;
      bit   acc1;
      bit   ok;
      int   q_s[$];
      int   q_l[$];
      int   q_o[$];
      bit   last;
      int   g0;
      int   g1;
      bit   exp_r0;
      bit   exp_r1;

      // Rows 0..17: both links contend for 6 packets (the first is the
      // reset-release packet). Rows 18..29: only In1 is active, 4 packets.
      // Each packet spans three cycles: accept, S, Out.
      for (int k = 0; k < NV; k++) begin
         pkt = k / 3;
         ph  = k % 3;
         lk  = (k < 18) ? (pkt % 2 == 1) : 1'b1;
         tbl[k].d0   = 9'h0A1;
         tbl[k].d1   = 9'h1F3;
         tbl[k].e_r0 = (ph == 0) && !lk;
         tbl[k].e_r1 = (ph == 0) && lk;
         tbl[k].e_sv = (ph == 1);
         tbl[k].e_sd = lk;
         tbl[k].e_ov = (ph == 2);
         tbl[k].e_od = lk ? 9'h1F3 : 9'h0A1;
      end
      // A producer keeps valid high until its last packet is taken.
      seen0 = 1'b0;
      seen1 = 1'b0;
      for (int k = NV - 1; k >= 0; k--) begin
         seen0 = seen0 | tbl[k].e_r0;
         seen1 = seen1 | tbl[k].e_r1;
         tbl[k].v0 = seen0;
         tbl[k].v1 = seen1;
      end

      // ---- reset: two cycles, both links already offering ----
      RESET = 1'b1;
      in0_valid = 1'b1; in0_data = 9'h0A1;
      in1_valid = 1'b1; in1_data = 9'h1F3;
      s_ready = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("rst%0d_in0_ready", c), int'(in0_ready), 0);
         chk($sformatf("rst%0d_in1_ready", c), int'(in1_ready), 0);
         chk($sformatf("rst%0d_s_valid", c), int'(s_valid), 0);
         chk($sformatf("rst%0d_out_valid", c), int'(out_valid), 0);
         step();
      end
      RESET = 1'b0;
      chk("rst_s_data", int'(s_data), 0);
      chk("rst_out_data", int'(out_data), 0);

      // ---- table-driven vectors ----
      for (int i = 0; i < NV; i++) begin
         in0_valid = tbl[i].v0; in0_data = tbl[i].d0;
         in1_valid = tbl[i].v1; in1_data = tbl[i].d1;
         #1;
         chk($sformatf("vec%0d_in0_ready", i), int'(in0_ready), int'(tbl[i].e_r0));
         chk($sformatf("vec%0d_in1_ready", i), int'(in1_ready), int'(tbl[i].e_r1));
         chk($sformatf("vec%0d_s_valid", i), int'(s_valid), int'(tbl[i].e_sv));
         chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
         if (tbl[i].e_sv) chk($sformatf("vec%0d_s_data", i), int'(s_data), int'(tbl[i].e_sd));
         if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(tbl[i].e_od));
         $display("vec %0d: r0=%0d r1=%0d s=%0d/%0d out=%0d/%03h", i, in0_ready, in1_ready,
                  s_valid, s_data, out_valid, out_data);
         step();
      end

      // ---- Out backpressure for 5 cycles ----
      in0_valid = 1'b1; in0_data = 9'h0C3; in1_valid = 1'b0;
      s_ready = 1'b1; out_ready = 1'b1;
      #1;
      chk("bp_in0_ready", int'(in0_ready), 1);
      chk("bp_in1_ready", int'(in1_ready), 0);
      step();
      in0_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("bp_s_valid", int'(s_valid), 1);
      chk("bp_s_data", int'(s_data), 0);
      step();
      in0_valid = 1'b1; in0_data = 9'h022;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp%0d_out_valid", c), int'(out_valid), 1);
         chk($sformatf("bp%0d_out_data", c), int'(out_data), 'h0C3);
         chk($sformatf("bp%0d_in0_ready", c), int'(in0_ready), 0);
         chk($sformatf("bp%0d_in1_ready", c), int'(in1_ready), 0);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_out_valid", int'(out_valid), 1);
      chk("bp_release_out_data", int'(out_data), 'h0C3);
      $display("bp: packet 0x0C3 released after 5 stalled cycles");
      step();
      #1;
      chk("bp_done_out_valid", int'(out_valid), 0);
      chk("bp_next_in0_ready", int'(in0_ready), 1);
      step();
      in0_valid = 1'b0;
      step();

      // ---- reset while 0x022 sits in SEND_OUT ----
      out_ready = 1'b0;
      #1;
      chk("mrst_pre_out_valid", int'(out_valid), 1);
      chk("mrst_pre_out_data", int'(out_data), 'h022);
      RESET = 1'b1;
      #1;
      chk("mrst_during_out_valid", int'(out_valid), 0);
      step();
      RESET = 1'b0;
      in0_valid = 1'b1; in0_data = 9'h0A1;
      in1_valid = 1'b1; in1_data = 9'h1F3;
      out_ready = 1'b1;
      #1;
      chk("mrst_after_out_valid", int'(out_valid), 0);
      chk("mrst_after_s_valid", int'(s_valid), 0);
      chk("mrst_first_grant_in0", int'(in0_ready), 1);
      chk("mrst_first_grant_in1", int'(in1_ready), 0);
      n_out = 0;
      seen_bad = 0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid && out_ready) begin
            n_out++;
            if (out_data == 9'h022) seen_bad++;
         end
         acc0 = in0_valid && in0_ready;
         acc1 = in1_valid && in1_ready;
         step();
         if (acc0) in0_valid = 1'b0;
         if (acc1) in1_valid = 1'b0;
         #1;
      end
      chk("mrst_out_count", n_out, 2);
      chk("mrst_dropped_pkt_seen", seen_bad, 0);
      $display("mrst: %0d packets forwarded after reset, dropped packet seen %0d times", n_out, seen_bad);
      step();

`ifdef ARB_STATS_EN
      // ---- saturating grant counters (CNT_W=2) ----
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      s_ready = 1'b1; out_ready = 1'b1;
      for (int p = 0; p < 5; p++) begin
         in0_valid = 1'b1; in0_data = W'(p + 1);
         wait_rdy(0, ok);
         chk($sformatf("stat%0d_ready_seen", p), int'(ok), 1);
         step();
         in0_valid = 1'b0;
         #1;
         chk($sformatf("stat%0d_cnt0", p), int'(stat_cnt0), (p + 1 > 3) ? 3 : p + 1);
         chk($sformatf("stat%0d_cnt1", p), int'(stat_cnt1), 0);
         $display("stat %0d: cnt0=%0d cnt1=%0d", p, stat_cnt0, stat_cnt1);
         step();
         step();
      end
`endif

      // ---- randomized traffic against the transaction model ----
      RESET = 1'b1;
      in0_valid = 1'b0; in1_valid = 1'b0;
      step();
      RESET = 1'b0;
      last = 1'b1;
      g0 = 0;
      g1 = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (!in0_valid && $urandom_range(0, 9) < 6) begin
            in0_valid = 1'b1; in0_data = W'($urandom_range(0, 511));
         end
         if (!in1_valid && $urandom_range(0, 9) < 6) begin
            in1_valid = 1'b1; in1_data = W'($urandom_range(0, 511));
         end
         s_ready   = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc0 = in0_valid && in0_ready;
         acc1 = in1_valid && in1_ready;
         if (q_o.size() == 0) begin
            exp_r0 = in0_valid && (!in1_valid || last);
            exp_r1 = in1_valid && (!in0_valid || !last);
            chk("rnd_in0_ready", int'(in0_ready), int'(exp_r0));
            chk("rnd_in1_ready", int'(in1_ready), int'(exp_r1));
            chk("rnd_idle_s_valid", int'(s_valid), 0);
            chk("rnd_idle_out_valid", int'(out_valid), 0);
            if (acc0) begin
               q_s.push_back(0); q_l.push_back(0); q_o.push_back(int'(in0_data)); g0++;
               $display("rnd %0d: accept link0 data 0x%03h", cyc, in0_data);
            end else if (acc1) begin
               q_s.push_back(1); q_l.push_back(1); q_o.push_back(int'(in1_data)); g1++;
               $display("rnd %0d: accept link1 data 0x%03h", cyc, in1_data);
            end
         end else begin
            chk("rnd_busy_in0_ready", int'(in0_ready), 0);
            chk("rnd_busy_in1_ready", int'(in1_ready), 0);
            chk("rnd_s_valid", int'(s_valid), int'(q_s.size() != 0));
            chk("rnd_out_valid", int'(out_valid), int'(q_s.size() == 0));
            if (s_valid && q_s.size() != 0) begin
               chk("rnd_s_data", int'(s_data), q_s[0]);
               if (s_ready) void'(q_s.pop_front());
            end else if (out_valid && q_s.size() == 0) begin
               chk("rnd_out_data", int'(out_data), q_o[0]);
               if (out_ready) begin
                  $display("rnd %0d: out link%0d data 0x%03h", cyc, q_l[0], out_data);
                  last = (q_l[0] == 1);
                  void'(q_o.pop_front());
                  void'(q_l.pop_front());
               end
            end
         end
         step();
         if (acc0) in0_valid = 1'b0;
         if (acc1) in1_valid = 1'b0;
      end
      chk("rnd_link0_served", int'(g0 > 0), 1);
      chk("rnd_link1_served", int'(g1 > 0), 1);
`ifdef ARB_STATS_EN
      #1;
      chk("rnd_stat_cnt0", int'(stat_cnt0), (g0 > 3) ? 3 : g0);
      chk("rnd_stat_cnt1", int'(stat_cnt1), (g1 > 3) ? 3 : g1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
